// File: rtl/bram_port_arbiter_pkg.sv
// Shared helpers for the BRAM port arbiter slice.
// Widths are parameter-derived inside each module, so no typedefs live here.
package bram_port_arbiter_pkg;

  // Wraps a search index that has run at most one lap past n-1.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Forced idle while rst is high so the caller needs no extra gating.
module rr_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PW = $clog2(NUM_REQ)
) (
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      gnt_idx,
  output logic               any
);

  logic [PW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = '0;
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_idx = PW'(rr_wrap(32'(ptr) + k, NUM_REQ));
        if (!any && req[w_idx]) begin
          any          = 1'b1;
          gnt_idx      = w_idx;
          gnt[w_idx]   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin share of one read-first BRAM port among NUM_REQ requesters,
// with a one-deep response buffer per requester.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned WE_UNIT_WIDTH = 8
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_REQ-1:0]                             req_valid,
  output logic [NUM_REQ-1:0]                             req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]                  req_addr,
  input  logic [NUM_REQ*(DATA_WIDTH/WE_UNIT_WIDTH)-1:0]  req_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                  req_wrdata,
  output logic [NUM_REQ-1:0]                             resp_valid,
  input  logic [NUM_REQ-1:0]                             resp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0]                  resp_rddata,
  output logic                                           mem_en,
  output logic [DATA_WIDTH/WE_UNIT_WIDTH-1:0]            mem_we,
  output logic [ADDR_WIDTH-1:0]                          mem_addr,
  output logic [DATA_WIDTH-1:0]                          mem_wrdata,
  input  logic [DATA_WIDTH-1:0]                          mem_rddata
);

  localparam int unsigned WE_WIDTH = DATA_WIDTH / WE_UNIT_WIDTH;
  localparam int unsigned PW       = $clog2(NUM_REQ);

  logic [PW-1:0]              r_rr_ptr;
  logic                       r_inflight_valid;
  logic [PW-1:0]              r_inflight_id;
  logic [NUM_REQ-1:0]         r_resp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] r_resp_rddata;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic [PW-1:0]      w_gnt_idx;
  logic               w_any;

  // A slot is free if empty or being drained this edge; the in-flight owner waits.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_valid[i]
                  && !(r_inflight_valid && (r_inflight_id == PW'(i)))
                  && (!r_resp_valid[i] || resp_ready[i]);
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .rst     (rst),
    .req     (w_elig),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  always_comb begin
    mem_we     = '0;
    mem_addr   = '0;
    mem_wrdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        mem_we     = req_we[i*WE_WIDTH +: WE_WIDTH];
        mem_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wrdata = req_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign mem_en      = w_any;
  assign req_ready   = w_gnt;
  assign resp_valid  = r_resp_valid;
  assign resp_rddata = r_resp_rddata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr         <= '0;
      r_inflight_valid <= 1'b0;
      r_inflight_id    <= '0;
      r_resp_valid     <= '0;
      r_resp_rddata    <= '0;
    end else begin
      r_inflight_valid <= w_any;
      if (w_any) begin
        r_inflight_id <= w_gnt_idx;
        r_rr_ptr      <= (w_gnt_idx == PW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PW'(1);
      end
      // Capture takes priority over a same-edge consume of the old response.
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (r_inflight_valid && (r_inflight_id == PW'(i))) begin
          r_resp_valid[i]                          <= 1'b1;
          r_resp_rddata[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rddata;
        end else if (r_resp_valid[i] && resp_ready[i]) begin
          r_resp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of dual_port_bram among NUM_REQ requesters using round-robin arbitration.
- Each requester has a valid/ready request channel (read or byte-masked write) and a valid/ready response channel.
- The block sequences the BRAM port's fixed 1-cycle read-first latency and buffers each response until its requester accepts it.
- Sits between CPU/DMA-style clients and the BRAM; the other BRAM port stays free for other uses.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥ 2.
- ADDR_WIDTH, 16: BRAM address width.
- DATA_WIDTH, 64: BRAM data width.
- WE_UNIT_WIDTH, 8: bits per write-enable bit. DATA_WIDTH must be a multiple of it.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (grant).
- req_addr  in  NUM_REQ x ADDR_WIDTH  request address.
- req_we  in  NUM_REQ x DATA_WIDTH/WE_UNIT_WIDTH  write enables; all-zero means a read.
- req_wrdata  in  NUM_REQ x DATA_WIDTH  write data.
- resp_valid  out  NUM_REQ  response held for the requester.
- resp_ready  in  NUM_REQ  requester consumes the response.
- resp_rddata  out  NUM_REQ x DATA_WIDTH  read-first data at the address; also returned for writes.
- mem_en  out  1  to BRAM port en.
- mem_we  out  DATA_WIDTH/WE_UNIT_WIDTH  to BRAM port we.
- mem_addr  out  ADDR_WIDTH  to BRAM port addr.
- mem_wrdata  out  DATA_WIDTH  to BRAM port wrdata.
- mem_rddata  in  DATA_WIDTH  from BRAM port rddata.

Behaviour:
- Reset (rst=1 at posedge):
  - rr_ptr=0, inflight_valid=0, resp_valid=0, resp_rddata=0.
  - While rst=1: req_ready=0 and mem_en=0, combinationally forced.
  - BRAM contents are not touched. A write issued before reset still completes. An inflight read response is dropped.
- Eligibility:
  - elig[i] = req_valid[i] && !(inflight_valid && inflight_id==i) && (!resp_valid[i] || resp_ready[i]).
  - A requester cannot be re-granted the cycle after its own grant, so per-requester rate is ≤ 1 per 2 cycles. Aggregate rate is 1 per cycle.
- Arbitration (combinational, same cycle):
  - Search elig starting at rr_ptr, ascending, wrapping at NUM_REQ-1 → 0. The first hit g is granted.
  - At most one req_ready bit is high. req_ready never depends on req_valid of other requesters beyond priority.
- Issue on grant (cycle t):
  - mem_en=1; mem_we/mem_addr/mem_wrdata = requester g's fields, combinational pass-through.
  - Next edge: inflight_valid<=1, inflight_id<=g, rr_ptr<=(g+1) mod NUM_REQ.
  - No grant: mem_en=0, mem_we=0, inflight_valid<=0, rr_ptr unchanged.
- Capture (cycle t+1):
  - mem_rddata is valid. At the edge ending t+1: resp_rddata[id]<=mem_rddata, resp_valid[id]<=1.
  - resp_valid is therefore visible in cycle t+2 (accept-to-response latency 2).
- Response handshake:
  - resp_valid[i] && resp_ready[i] at an edge clears resp_valid[i], unless a capture for i happens at the same edge. In that case the capture wins and resp_valid stays 1 with the new data. Eligibility guarantees the old response was consumed.
  - resp_rddata[i] is stable while resp_valid[i]=1 and not consumed.
- Requester obligations:
  - req_* must be held stable while req_valid=1 and req_ready=0. The block tolerates violations without assertion.
- Hazards:
  - BRAM is read-first. A read granted the cycle after a write to the same address returns the written data, because the BRAM write has completed.
  - Write responses carry the old (pre-write) data.
- Width:
  - rr_ptr and inflight_id are $clog2(NUM_REQ) bits.
  - rr_ptr wrap is an explicit compare to NUM_REQ-1, not power-of-2 truncation.

Decomposition:
- Shared package: no new typedefs, since widths are parameter-derived locally.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, ptr, rst; outputs one-hot gnt, gnt_idx, any.
  - Purely combinational.
  - rr_ptr register stays in bram_port_arbiter.
  - Reusable by other shared-resource controllers.

Test Plan:
- Single read: preload mem[0x10]=0xDEAD. Requester 1 reads 0x10 at cycle 0 → req_ready[1]=1 cycle 0, mem_en=1, resp_valid[1]=1 cycle 2, resp_rddata[1]=0xDEAD.
- Fairness: all 4 requesters hold req_valid with resp_ready=1 → grant order 0,1,2,3,0,... one grant per cycle. No requester is granted twice within 4 consecutive grants.
- Write then read: requester 0 writes 0x20 with we=0x0F, data=0x1111_2222_3333_4444 over old 0xFFFF_FFFF_FFFF_FFFF.
  - Write response returns 0xFFFF_FFFF_FFFF_FFFF.
  - Requester 2's next-cycle read of 0x20 returns 0xFFFF_FFFF_3333_4444.
- Backpressure: requester 3 has resp_ready=0 with a pending response, plus a new req_valid → req_ready[3] stays 0 and resp_rddata[3] is stable. When resp_ready[3]=1, that same cycle req_ready[3]=1 and the new response arrives 2 cycles later.
- Same-requester spacing: only requester 2 is active, continuous req_valid, resp_ready=1 → grants in alternating cycles (0,2,4,...). mem_en=0 on odd cycles.
- Reset mid-operation: assert rst in the cycle after a grant to requester 1 → resp_valid all 0 after the edge, req_ready=0 during rst, rr_ptr=0. The first grant after reset goes to the lowest valid index.
